mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port external memory between the two Bambu master channels (lanes 0/1) of an HLS top.
//  Round-robin arbitration; one access in flight at a time. Lane response (M_Rdata_ram/M_DataRdy) follows Bambu semantics.
//  Sits between the HLS core Mout_* bus and the board/testbench memory model.
// PARAMETERS
//  ADDR_W   7   per-lane address width
//  DATA_W   8   per-lane data width
//  SIZE_W   4   per-lane access-size field width
//  RD_LAT   2   memory read latency in cycles from mem_cs (>=1)
// PORTS
//  clock               in   1          rising-edge clock
//  reset               in   1          async, active-low
//  Mout_oe_ram         in   2          per-lane read request
//  Mout_we_ram         in   2          per-lane write request
//  Mout_addr_ram       in   2*ADDR_W   lane i at [i*ADDR_W +: ADDR_W]
//  Mout_Wdata_ram      in   2*DATA_W   per-lane write data
//  Mout_data_ram_size  in   2*SIZE_W   per-lane access size (bits)
//  M_Rdata_ram         out  2*DATA_W   read data; zero on non-responding lane
//  M_DataRdy           out  2          one-cycle completion strobe per lane
//  mem_cs              out  1          memory access strobe
//  mem_we              out  1          1=write, 0=read (valid with mem_cs)
//  mem_addr            out  ADDR_W     memory address
//  mem_wdata           out  DATA_W     memory write data
//  mem_size            out  SIZE_W     memory access size
//  mem_rdata           in   DATA_W     valid exactly RD_LAT cycles after mem_cs
//  proto_err           out  1          sticky: a lane raised oe and we together
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE, rr pointer favours lane 0, all outputs 0, proto_err=0, stat counters 0.
//  - Request on lane i = oe[i]^we[i]. oe[i]&we[i] -> lane ignored, proto_err set (cleared only by reset).
//  - FSM IDLE: on any valid request, grant it (both valid -> lane opposite last grant) and register addr/wdata/size/we
//    -> ISSUE; else stay.
//  - ISSUE (1 cycle): mem_cs=1, mem_* from registers. Write -> RESP; read -> WAIT with cnt=RD_LAT-1.
//  - WAIT: decrement cnt; capture mem_rdata when cnt==0 -> RESP (so read is sampled RD_LAT cycles after mem_cs).
//  - RESP (1 cycle): M_DataRdy[g]=1; for read, M_Rdata_ram lane g = captured data. Update rr pointer to g -> IDLE.
//  - Latency from request seen in IDLE: write DataRdy at cycle 2, read DataRdy at cycle 2+RD_LAT.
//  - Requests are held by the lane until DataRdy; request still high in RESP is not re-granted (RESP always -> IDLE).
//  - Request dropped mid-transaction: the access completes and DataRdy still pulses.
//  - Only low size bits used by memory; the arbiter passes mem_size through unmodified, with no masking.
//  - mem_* and M_* are zero outside ISSUE/RESP respectively. Throughput: one access per 3 (wr) / 3+RD_LAT (rd) cycles.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds outputs stat_grants (2x16) and stat_wait (2x16). Counters are saturating:
//    grants counts RESP cycles per lane; wait counts cycles a lane has a valid request and is not granted.
//  Undefined: ports and counters absent; all other behaviour is identical.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE,ISSUE,WAIT,RESP}, LANES=2, STAT_W=16.
//  Sub-module rr_arbiter2: combinational next-grant from req[1:0] and last-grant bit.
// TESTING
//  1. Lane0 write addr 5, data 8'hA5, size 8 -> mem_cs/mem_we at cycle 1, DataRdy[0] at cycle 2.
//  2. Lane1 read addr 5 after test 1, RD_LAT=2 -> DataRdy[1] at cycle 4, Rdata[15:8]=8'hA5, Rdata[7:0]=0.
//  3. Both lanes read every cycle for 8 accesses -> grants alternate 0,1,0,1...; no lane is starved.
//  4. Lane0 raises oe and we together -> proto_err=1 and no mem_cs; lane1 traffic is still served.
//  5. Reset asserted during WAIT -> outputs 0 immediately; after release, a lane1-only request is served normally.
//  6. MEM_ARB_STATS_EN defined, run test 3 -> stat_grants={4,4}; stat_wait per lane equals the bench-counted stall cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-lane memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LANES  = 2;
    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin chooser: picks the lane opposite the last grant when both request.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       grant
);

    always_comb begin
        any   = |req;
        grant = 1'b0;
        if (req[0] && req[1]) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between two Bambu master lanes, one access in flight at a time.
// Optional MEM_ARB_STATS_EN adds saturating per-lane grant and wait counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4,
    parameter int RD_LAT = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LANES-1:0]          Mout_oe_ram,
    input  logic [LANES-1:0]          Mout_we_ram,
    input  logic [LANES*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [LANES*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [LANES*SIZE_W-1:0]   Mout_data_ram_size,
    output logic [LANES*DATA_W-1:0]   M_Rdata_ram,
    output logic [LANES-1:0]          M_DataRdy,
    output logic                      mem_cs,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [SIZE_W-1:0]         mem_size,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      proto_err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [LANES*STAT_W-1:0]   stat_grants,
    output logic [LANES*STAT_W-1:0]   stat_wait
`endif
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state_reg, state_next;
    logic [LANES-1:0]    valid;
    logic [ADDR_W-1:0]   lane_addr  [LANES];
    logic [DATA_W-1:0]   lane_wdata [LANES];
    logic [SIZE_W-1:0]   lane_size  [LANES];
    logic                grant_any, grant_lane;

    logic                g_reg, last_reg, we_reg, proto_err_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg, rdata_reg;
    logic [SIZE_W-1:0]   size_reg;
    logic [CNT_W-1:0]    cnt_reg;

    // A lane requests only when exactly one of oe/we is high.
    assign valid = Mout_oe_ram ^ Mout_we_ram;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_unpack
            assign lane_addr[gi]  = Mout_addr_ram[gi*ADDR_W +: ADDR_W];
            assign lane_wdata[gi] = Mout_Wdata_ram[gi*DATA_W +: DATA_W];
            assign lane_size[gi]  = Mout_data_ram_size[gi*SIZE_W +: SIZE_W];
        end
    endgenerate

    rr_arbiter2 u_rr (
        .req   (valid),
        .last  (last_reg),
        .any   (grant_any),
        .grant (grant_lane)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            g_reg         <= 1'b0;
            last_reg      <= 1'b1;
            we_reg        <= 1'b0;
            proto_err_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            size_reg      <= '0;
            rdata_reg     <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (|(Mout_oe_ram & Mout_we_ram)) begin
                proto_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        g_reg     <= grant_lane;
                        we_reg    <= Mout_we_ram[grant_lane];
                        addr_reg  <= lane_addr[grant_lane];
                        wdata_reg <= lane_wdata[grant_lane];
                        size_reg  <= lane_size[grant_lane];
                    end
                end
                ISSUE: cnt_reg <= CNT_W'(RD_LAT - 1);
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        rdata_reg <= mem_rdata;
                    end
                end
                RESP: last_reg <= g_reg;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = ISSUE;
            ISSUE:   state_next = we_reg ? RESP : WAIT;
            WAIT:    if (cnt_reg == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs are zero except during the single ISSUE cycle.
    always_comb begin
        mem_cs    = (state_reg == ISSUE);
        mem_we    = mem_cs & we_reg;
        mem_addr  = mem_cs ? addr_reg  : '0;
        mem_wdata = mem_cs ? wdata_reg : '0;
        mem_size  = mem_cs ? size_reg  : '0;
    end

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_resp
            logic lane_resp;
            assign lane_resp = (state_reg == RESP) && (g_reg == 1'(gi));
            assign M_DataRdy[gi] = lane_resp;
            assign M_Rdata_ram[gi*DATA_W +: DATA_W] = (lane_resp && !we_reg) ? rdata_reg : '0;
        end
    endgenerate

    assign proto_err = proto_err_reg;

`ifdef MEM_ARB_STATS_EN
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_stats
            logic [STAT_W-1:0] grants_reg, wait_reg;
            logic              owner, granting;
            assign owner    = (state_reg != IDLE) && (g_reg == 1'(gi));
            assign granting = (state_reg == IDLE) && grant_any && (grant_lane == 1'(gi));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    grants_reg <= '0;
                    wait_reg   <= '0;
                end else begin
                    if (M_DataRdy[gi]) begin
                        grants_reg <= sat_inc(grants_reg);
                    end
                    if (valid[gi] && !owner && !granting) begin
                        wait_reg <= sat_inc(wait_reg);
                    end
                end
            end

            assign stat_grants[gi*STAT_W +: STAT_W] = grants_reg;
            assign stat_wait[gi*STAT_W +: STAT_W]   = wait_reg;
        end
    endgenerate
`endif

endmodule
